online_softmax_sched: RTL and testbench
=======================================

// Module: online_softmax_sched
// PURPOSE
//  Per-query-row scheduler for the online-softmax (FlashAttention) datapath. Consumes a stream of
//  SCORE_QT logits (Q4.3) for one query row and tracks the running max. Emits one rescale op per key
//  to the expmul/V-accumulator: base-2 right-shift amounts for the old accumulator and new V term.
//  After the last key it starts the divider, waits for it to finish, then signals row completion.
// PARAMETERS
//  MAX_KEYS   512                      max keys per row
//  KEY_W      $clog2(MAX_KEYS+1) (10)  width of num_keys / key counter
//  SHIFT_MAX  15                       saturation value of a shift amount (EXPMUL_EXPONENT_QT range)
// PORTS
//  clock         in   1      single clock; all logic on rising edge
//  reset         in   1      synchronous, active-high
//  start         in   1      begin row; sampled only in IDLE
//  num_keys      in   KEY_W  keys in this row, sampled with start; must be <= MAX_KEYS
//  busy          out  1      high in every state except IDLE
//  score_valid   in   1      score stream valid
//  score_ready   out  1      score stream ready
//  score         in   8      SCORE_QT (signed Q4.3)
//  op_valid      out  1      rescale op valid
//  op_ready      in   1      rescale op accepted by expmul
//  op_shift_old  out  4      right shift applied to accumulated numerator/denominator
//  op_shift_new  out  4      right shift applied to this key's V term / "1"
//  op_first      out  1      op is for key 0 (accumulator is empty)
//  op_last       out  1      op is for key num_keys-1
//  row_max       out  8      running max, SCORE_QT
//  div_start     out  1      one-cycle pulse: start final division
//  div_done      in   1      divider finished (single-cycle pulse)
//  row_done      out  1      one-cycle pulse: row complete
// BEHAVIOUR
//  Reset: state=IDLE; busy, score_ready, op_valid, op_first, op_last, div_start, row_done = 0;
//   op_shift_old/new = 0; row_max = 8'h80; key counter = 0. Reset mid-row abandons the row, no pulses.
//  FSM: IDLE -start&num_keys!=0-> RUN; IDLE -start&num_keys==0-> DONE (no op, no div_start).
//   RUN -handshake of key num_keys-1-> DRAIN; DRAIN -op accepted-> DIV (div_start pulses on entry cycle);
//   DIV -div_done-> DONE; DONE -> IDLE (row_done high for exactly the one DONE cycle).
//   start outside IDLE ignored. div_done outside DIV ignored.
//  Handshakes: score_ready = (state==RUN) & (!op_valid | op_ready). Score accepted on valid&ready;
//   op registered the next cycle (latency 1). op_valid holds and op fields are stable until op_ready.
//   Score and op handshakes in the same cycle are legal (throughput 1 key/cycle).
//  Shift math, per accepted score s vs current max m (first key: m undefined):
//   a = |s - m| as unsigned 8b, units 2^-3 (max 255); t = a + (a>>1) - (a>>4) (9b, ~a*log2e);
//   L = min(SHIFT_MAX, t>>3).
//   first key: shift_old=0, shift_new=0, m<=s, op_first=1.
//   s >  m:    shift_old=L, shift_new=0, m<=s.
//   s <= m:    shift_old=0, shift_new=L, m unchanged (tie -> L=0, both shifts 0).
//  op_last = 1 on op of key num_keys-1. row_max updates in the same cycle the op registers.
//  Key counter wraps to 0 on row entry; never exceeds num_keys.
// STRUCTURE
//  Shared pkg: SCORE_QT, EXPMUL_EXPONENT_QT, SHIFT_MAX, function log2e_approx(a) (t formula above),
//   typedef struct packed rescale_op_t {shift_old, shift_new, first, last}.
//  One combinational sub-module expmul_shift_calc: (s, m, first) -> (shift_old, shift_new, new_max).
//  Top holds FSM, key counter, op register, max register.
// TESTING
//  1 reset: hold reset 3 cycles -> all outputs at reset values, row_max=8'h80, busy=0.
//  2 num_keys=3, scores 8'h08,8'h18,8'h10 (1.0,3.0,2.0) -> ops (old,new,first,last) = (0,0,1,0),
//    (2,0,0,0) [a=16,t=23], (0,1,0,1) [a=8,t=12]; row_max=8'h18; div_start 1-cycle pulse;
//    div_done 5 cycles later -> row_done next cycle, then busy=0.
//  3 backpressure: op_ready=0 for 4 cycles mid-row -> score_ready=0, op fields stable, no key lost/duplicated.
//  4 saturation: num_keys=2, scores 8'h80 then 8'h7F -> a=255,t=367 -> second op (15,0); row_max=8'h7F.
//  5 num_keys=0 with start -> row_done one cycle later, no op_valid, no div_start.
//  6 reset asserted during RUN after 2 of 4 keys -> reset values next cycle; new start runs cleanly.

Source files
------------

// File: rtl/online_softmax_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module : online_softmax_sched_pkg
// Brief  : Shared types, constants and the log2(e) helper for the softmax scheduler.
// Rev    : 1.0
// ============================================================================
package online_softmax_sched_pkg;

    localparam int MAX_KEYS  = 512;
    localparam int KEY_W     = $clog2(MAX_KEYS + 1);
    localparam int SHIFT_MAX = 15;

    typedef logic signed [7:0] score_qt_t;
    typedef logic [3:0]        expmul_exponent_qt_t;

    localparam score_qt_t c_score_min = 8'sh80;

    typedef struct packed {
        expmul_exponent_qt_t shift_old;
        expmul_exponent_qt_t shift_new;
        logic                first;
        logic                last;
    } rescale_op_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_DIV   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // a * log2(e) ~= a * (1 + 1/2 - 1/16); worst case 367 still fits 9 bits
    function automatic logic [8:0] log2e_approx(input logic [7:0] a);
        logic [8:0] w_a;
        w_a = {1'b0, a};
        return w_a + (w_a >> 1) - (w_a >> 4);
    endfunction

endpackage
`default_nettype wire

// File: rtl/online_softmax_sched_if.sv
`default_nettype none
// ============================================================================
// Module : online_softmax_sched_if
// Brief  : Control, score stream, rescale-op and divider signals of the scheduler.
// Rev    : 1.0
// ============================================================================
interface online_softmax_sched_if;
    import online_softmax_sched_pkg::*;

    logic                start;
    logic [KEY_W-1:0]    num_keys;
    logic                busy;
    logic                score_valid;
    logic                score_ready;
    logic [7:0]          score;
    logic                op_valid;
    logic                op_ready;
    logic [3:0]          op_shift_old;
    logic [3:0]          op_shift_new;
    logic                op_first;
    logic                op_last;
    logic [7:0]          row_max;
    logic                div_start;
    logic                div_done;
    logic                row_done;

    modport master (
        output start, num_keys, score_valid, score, op_ready, div_done,
        input  busy, score_ready, op_valid, op_shift_old, op_shift_new,
               op_first, op_last, row_max, div_start, row_done
    );

    modport slave (
        input  start, num_keys, score_valid, score, op_ready, div_done,
        output busy, score_ready, op_valid, op_shift_old, op_shift_new,
               op_first, op_last, row_max, div_start, row_done
    );
endinterface
`default_nettype wire

// File: rtl/online_softmax_sched_expmul_shift_calc.sv
`default_nettype none
// ============================================================================
// Module : expmul_shift_calc
// Brief  : Combinational base-2 rescale shifts and updated max for one score.
// Rev    : 1.0
// ============================================================================
module expmul_shift_calc
    import online_softmax_sched_pkg::*;
(
    input  score_qt_t           i_s,
    input  score_qt_t           i_m,
    input  logic                i_first,
    output expmul_exponent_qt_t o_shift_old,
    output expmul_exponent_qt_t o_shift_new,
    output score_qt_t           o_new_max
);

    logic signed [8:0]   w_diff;
    logic [7:0]          w_abs;
    logic [8:0]          w_t;
    logic [5:0]          w_l;
    expmul_exponent_qt_t w_lsat;

    assign w_diff = {i_s[7], i_s} - {i_m[7], i_m};
    assign w_abs  = 8'(w_diff[8] ? -w_diff : w_diff);
    assign w_t    = log2e_approx(w_abs);
    assign w_l    = 6'(w_t >> 3);
    assign w_lsat = (w_l > 6'(SHIFT_MAX)) ? 4'(SHIFT_MAX) : w_l[3:0];

    // The larger of the two exponents becomes the new reference; only the
    // smaller-side term is shifted down.
    always_comb begin
        o_shift_old = '0;
        o_shift_new = '0;
        o_new_max   = i_m;
        if (i_first) begin
            o_new_max = i_s;
        end else if (i_s > i_m) begin
            o_shift_old = w_lsat;
            o_new_max   = i_s;
        end else begin
            o_shift_new = w_lsat;
        end
    end

endmodule
`default_nettype wire

// File: rtl/online_softmax_sched.sv
`default_nettype none
// ============================================================================
// Module : online_softmax_sched
// Brief  : Per-query-row online-softmax scheduler: running max, rescale ops, divider hand-off.
// Rev    : 1.0
// ============================================================================
module online_softmax_sched
    import online_softmax_sched_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    online_softmax_sched_if.slave bus
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [KEY_W-1:0]    r_num_keys;
    logic [KEY_W-1:0]    r_key_cnt;
    rescale_op_t         r_op;
    logic                r_op_valid;
    score_qt_t           r_row_max;
    logic                r_div_start;

    logic                w_score_ready;
    logic                w_busy;
    logic                w_row_done;
    logic                w_score_acc;
    logic                w_op_acc;
    logic                w_first_key;
    logic                w_last_key;
    expmul_exponent_qt_t w_shift_old;
    expmul_exponent_qt_t w_shift_new;
    score_qt_t           w_new_max;

    assign w_score_acc = bus.score_valid & w_score_ready;
    assign w_op_acc    = r_op_valid & bus.op_ready;
    assign w_first_key = (r_key_cnt == '0);
    assign w_last_key  = (r_key_cnt == r_num_keys - KEY_W'(1));

    expmul_shift_calc u_shift_calc (
        .i_s         (score_qt_t'(bus.score)),
        .i_m         (r_row_max),
        .i_first     (w_first_key),
        .o_shift_old (w_shift_old),
        .o_shift_new (w_shift_new),
        .o_new_max   (w_new_max)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_score_ready = 1'b0;
        w_busy        = 1'b1;
        w_row_done    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) begin
                    w_state_nxt = (bus.num_keys == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                // A new score may enter only if the op slot is free or emptying now
                w_score_ready = ~r_op_valid | bus.op_ready;
                if (bus.score_valid & w_score_ready & w_last_key) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_op_acc) begin
                    w_state_nxt = S_DIV;
                end
            end
            S_DIV: begin
                if (bus.div_done) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_row_done  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_num_keys  <= '0;
            r_key_cnt   <= '0;
            r_op        <= '0;
            r_op_valid  <= 1'b0;
            r_row_max   <= c_score_min;
            r_div_start <= 1'b0;
        end else begin
            r_div_start <= (r_state == S_DRAIN) & w_op_acc;

            if ((r_state == S_IDLE) & bus.start) begin
                r_num_keys <= bus.num_keys;
                r_key_cnt  <= '0;
            end else if (w_score_acc) begin
                r_key_cnt <= r_key_cnt + KEY_W'(1);
            end

            if (w_score_acc) begin
                r_op_valid <= 1'b1;
                r_op       <= '{shift_old: w_shift_old,
                                shift_new: w_shift_new,
                                first:     w_first_key,
                                last:      w_last_key};
                r_row_max  <= w_new_max;
            end else if (w_op_acc) begin
                r_op_valid <= 1'b0;
            end
        end
    end

    assign bus.busy         = w_busy;
    assign bus.score_ready  = w_score_ready;
    assign bus.op_valid     = r_op_valid;
    assign bus.op_shift_old = r_op.shift_old;
    assign bus.op_shift_new = r_op.shift_new;
    assign bus.op_first     = r_op.first;
    assign bus.op_last      = r_op.last;
    assign bus.row_max      = r_row_max;
    assign bus.div_start    = r_div_start;
    assign bus.row_done     = w_row_done;

endmodule
`default_nettype wire

// File: tb/tb_online_softmax_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_online_softmax_sched
// Brief  : Randomized bench for the online-softmax scheduler against an arithmetic row model.
// Rev    : 1.0
// ============================================================================
module tb_online_softmax_sched;
    import online_softmax_sched_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    online_softmax_sched_if bus();

    online_softmax_sched dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int passed = 0;

    logic [7:0] scores_q[$];
    logic [9:0] exp_q[$];
    logic [9:0] got_q[$];
    logic [7:0] exp_max;

    int n_div_start, n_row_done, n_opv;
    int div_start_cyc, row_done_cyc, last_op_cyc;
    int stab_err, sr_err, timed_out;

    // Row model: walk the scores with integer arithmetic, op = {old, new, first, last}
    function automatic logic [7:0] model_row();
        int m, s, a, t, l;
        logic [3:0] so, sn;
        exp_q.delete();
        m = -128;
        foreach (scores_q[i]) begin
            s = int'($signed(scores_q[i]));
            so = 4'd0;
            sn = 4'd0;
            if (i == 0) begin
                m = s;
            end else begin
                a = (s > m) ? s - m : m - s;
                t = a + a / 2 - a / 16;
                l = (t / 8 > SHIFT_MAX) ? SHIFT_MAX : t / 8;
                if (s > m) begin
                    so = 4'(l);
                    m  = s;
                end else begin
                    sn = 4'(l);
                end
            end
            exp_q.push_back({so, sn, (i == 0), (i == scores_q.size() - 1)});
        end
        return 8'(m);
    endfunction

    task automatic idle_inputs();
        bus.start       = 1'b0;
        bus.num_keys    = '0;
        bus.score_valid = 1'b0;
        bus.score       = '0;
        bus.op_ready    = 1'b0;
        bus.div_done    = 1'b0;
    endtask

    // Drives one row from scores_q and records everything seen at negedges
    task automatic run_row(input int nk, input int vpct, input int rpct,
                           input int stall_at, input int stall_len, input bit noise);
        int idx, dd_cnt;
        bit dd_armed, drain_seen, prev_hold;
        logic [9:0] prev_op, cur_op;
        got_q.delete();
        n_div_start = 0; n_row_done = 0; n_opv = 0;
        div_start_cyc = -1; row_done_cyc = -1; last_op_cyc = -1;
        stab_err = 0; sr_err = 0; timed_out = 0;
        idx = 0; dd_cnt = 0; dd_armed = 0; drain_seen = 0; prev_hold = 0; prev_op = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clock); #1;
            bus.start       = (cyc == 0) ? 1'b1 : (noise && $urandom_range(0, 7) == 0);
            bus.num_keys    = (cyc == 0) ? KEY_W'(nk) : KEY_W'($urandom_range(0, MAX_KEYS));
            bus.score_valid = (idx < nk) && ($urandom_range(0, 99) < vpct);
            bus.score       = (idx < nk) ? scores_q[idx] : 8'($urandom);
            bus.op_ready    = (cyc >= stall_at && cyc < stall_at + stall_len) ? 1'b0
                              : ($urandom_range(0, 99) < rpct);
            bus.div_done    = 1'b0;
            if (dd_armed) begin
                dd_cnt--;
                if (dd_cnt == 0) begin
                    bus.div_done = 1'b1;
                    dd_armed = 0;
                end
            end else if (noise && !drain_seen) begin
                bus.div_done = ($urandom_range(0, 3) == 0);
            end
            @(negedge clock);
            cur_op = {bus.op_shift_old, bus.op_shift_new, bus.op_first, bus.op_last};
            if (prev_hold && (bus.op_valid !== 1'b1 || cur_op !== prev_op)) stab_err++;
            if (bus.op_valid && !bus.op_ready && bus.score_ready) sr_err++;
            prev_hold = bus.op_valid && !bus.op_ready;
            prev_op   = cur_op;
            if (bus.op_valid) n_opv++;
            if (bus.score_valid && bus.score_ready) idx++;
            if (bus.op_valid && bus.op_ready) begin
                got_q.push_back(cur_op);
                if (bus.op_last || got_q.size() >= nk) begin
                    last_op_cyc = cyc;
                    drain_seen  = 1;
                end
            end
            if (bus.div_start) begin
                n_div_start++;
                if (div_start_cyc < 0) begin
                    div_start_cyc = cyc;
                    dd_armed = 1;
                    dd_cnt   = 5;
                end
            end
            if (bus.row_done) begin
                n_row_done++;
                row_done_cyc = cyc;
                break;
            end
        end
        if (row_done_cyc < 0) timed_out = 1;
        @(posedge clock); #1;
        idle_inputs();
    endtask

    function automatic int queue_diffs();
        int bad;
        bad = (got_q.size() != exp_q.size()) ? 1 : 0;
        foreach (exp_q[i]) begin
            if (i < got_q.size() && got_q[i] !== exp_q[i]) bad++;
        end
        return bad;
    endfunction

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({bus.busy, bus.score_ready, bus.op_valid, bus.op_first, bus.op_last,
             bus.div_start, bus.row_done} !== 7'b0)
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {bus.busy, bus.score_ready, bus.op_valid, bus.op_first, bus.op_last,
                      bus.div_start, bus.row_done});
        else passed++;
        checks++;
        if ({bus.op_shift_old, bus.op_shift_new} !== 8'h00)
            $display("FAIL reset_shifts: got %h expected 00", {bus.op_shift_old, bus.op_shift_new});
        else passed++;
        checks++;
        if (bus.row_max !== 8'h80)
            $display("FAIL reset_row_max: got %h expected 80", bus.row_max);
        else passed++;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic test_basic_row();
        scores_q = '{8'h08, 8'h18, 8'h10};
        exp_max = model_row();
        run_row(3, 100, 100, -1, 0, 1'b0);
        checks++;
        if (got_q.size() !== 3) $display("FAIL basic_count: got %0d expected 3", got_q.size());
        else passed++;
        checks++;
        if (got_q[0] !== {4'd0, 4'd0, 1'b1, 1'b0}) $display("FAIL basic_op0: got %h expected %h", got_q[0], {4'd0, 4'd0, 1'b1, 1'b0});
        else passed++;
        checks++;
        if (got_q[1] !== {4'd2, 4'd0, 1'b0, 1'b0}) $display("FAIL basic_op1: got %h expected %h", got_q[1], {4'd2, 4'd0, 1'b0, 1'b0});
        else passed++;
        checks++;
        if (got_q[2] !== {4'd0, 4'd1, 1'b0, 1'b1}) $display("FAIL basic_op2: got %h expected %h", got_q[2], {4'd0, 4'd1, 1'b0, 1'b1});
        else passed++;
        checks++;
        if (bus.row_max !== 8'h18) $display("FAIL basic_row_max: got %h expected 18", bus.row_max);
        else passed++;
        checks++;
        if (n_div_start !== 1 || div_start_cyc !== last_op_cyc + 1)
            $display("FAIL basic_div_start: got pulses=%0d cyc=%0d expected pulses=1 cyc=%0d",
                     n_div_start, div_start_cyc, last_op_cyc + 1);
        else passed++;
        checks++;
        if (timed_out !== 0 || n_row_done !== 1 || row_done_cyc - div_start_cyc !== 6)
            $display("FAIL basic_row_done: got timeout=%0d pulses=%0d delay=%0d expected 0/1/6",
                     timed_out, n_row_done, row_done_cyc - div_start_cyc);
        else passed++;
        @(negedge clock);
        checks++;
        if (bus.busy !== 1'b0) $display("FAIL basic_busy_after: got %b expected 0", bus.busy);
        else passed++;
    endtask

    task automatic test_backpressure();
        scores_q.delete();
        for (int i = 0; i < 6; i++) scores_q.push_back(8'($urandom));
        exp_max = model_row();
        run_row(6, 100, 100, 3, 4, 1'b0);
        checks++;
        if (queue_diffs() !== 0) $display("FAIL bp_ops: got %0d mismatching ops expected 0", queue_diffs());
        else passed++;
        checks++;
        if (stab_err !== 0 || sr_err !== 0)
            $display("FAIL bp_stall: got stable_err=%0d ready_err=%0d expected 0/0", stab_err, sr_err);
        else passed++;
        checks++;
        if (bus.row_max !== exp_max) $display("FAIL bp_row_max: got %h expected %h", bus.row_max, exp_max);
        else passed++;
    endtask

    task automatic test_saturation();
        scores_q = '{8'h80, 8'h7F};
        exp_max = model_row();
        run_row(2, 100, 100, -1, 0, 1'b0);
        checks++;
        if (got_q.size() !== 2 || got_q[1] !== {4'd15, 4'd0, 1'b0, 1'b1})
            $display("FAIL sat_op: got n=%0d op1=%h expected n=2 op1=%h", got_q.size(), got_q[1], {4'd15, 4'd0, 1'b0, 1'b1});
        else passed++;
        checks++;
        if (bus.row_max !== 8'h7F) $display("FAIL sat_row_max: got %h expected 7f", bus.row_max);
        else passed++;
    endtask

    task automatic test_zero_keys();
        scores_q.delete();
        exp_max = model_row();
        run_row(0, 100, 100, -1, 0, 1'b0);
        checks++;
        if (row_done_cyc !== 1) $display("FAIL zero_row_done: got cyc %0d expected 1", row_done_cyc);
        else passed++;
        checks++;
        if (n_opv !== 0 || n_div_start !== 0)
            $display("FAIL zero_no_ops: got op_valid=%0d div_start=%0d expected 0/0", n_opv, n_div_start);
        else passed++;
    endtask

    task automatic test_reset_mid_row();
        int pulses;
        pulses = 0;
        @(posedge clock); #1;
        bus.start = 1'b1; bus.num_keys = KEY_W'(4); bus.op_ready = 1'b1;
        @(posedge clock); #1;
        bus.start = 1'b0; bus.score_valid = 1'b1; bus.score = 8'($urandom);
        @(negedge clock); if (bus.div_start || bus.row_done) pulses++;
        @(posedge clock); #1;
        bus.score = 8'($urandom);
        @(negedge clock); if (bus.div_start || bus.row_done) pulses++;
        @(posedge clock); #1;
        bus.score_valid = 1'b0; reset = 1'b1;
        @(negedge clock); if (bus.div_start || bus.row_done) pulses++;
        @(negedge clock);
        if (bus.div_start || bus.row_done) pulses++;
        checks++;
        if ({bus.busy, bus.score_ready, bus.op_valid, bus.op_first, bus.op_last,
             bus.op_shift_old, bus.op_shift_new, bus.row_max} !== {5'b0, 8'h00, 8'h80} || pulses !== 0)
            $display("FAIL midreset_state: got busy=%b opv=%b max=%h pulses=%0d expected 0/0/80/0",
                     bus.busy, bus.op_valid, bus.row_max, pulses);
        else passed++;
        @(posedge clock); #1;
        reset = 1'b0;
        scores_q.delete();
        for (int i = 0; i < 4; i++) scores_q.push_back(8'($urandom));
        exp_max = model_row();
        run_row(4, 80, 80, -1, 0, 1'b0);
        checks++;
        if (queue_diffs() !== 0 || bus.row_max !== exp_max || timed_out !== 0)
            $display("FAIL midreset_rerun: got diffs=%0d max=%h timeout=%0d expected 0/%h/0",
                     queue_diffs(), bus.row_max, timed_out, exp_max);
        else passed++;
    endtask

    task automatic test_random_rows();
        int nk;
        for (int r = 0; r < 8; r++) begin
            nk = $urandom_range(1, 24);
            scores_q.delete();
            for (int i = 0; i < nk; i++) begin
                if (i > 0 && $urandom_range(0, 3) == 0) scores_q.push_back(scores_q[i-1]);
                else scores_q.push_back(8'($urandom));
            end
            exp_max = model_row();
            run_row(nk, 60, 60, -1, 0, 1'b1);
            checks++;
            if (queue_diffs() !== 0) $display("FAIL rand_ops row %0d: got %0d mismatches expected 0", r, queue_diffs());
            else passed++;
            checks++;
            if (bus.row_max !== exp_max) $display("FAIL rand_row_max row %0d: got %h expected %h", r, bus.row_max, exp_max);
            else passed++;
            checks++;
            if (timed_out !== 0 || n_div_start !== 1 || n_row_done !== 1 || stab_err !== 0 || sr_err !== 0)
                $display("FAIL rand_flow row %0d: got to=%0d div=%0d done=%0d stab=%0d rdy=%0d expected 0/1/1/0/0",
                         r, timed_out, n_div_start, n_row_done, stab_err, sr_err);
            else passed++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running expected finish");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        test_reset();
        test_basic_row();
        test_backpressure();
        test_saturation();
        test_zero_keys();
        test_reset_mid_row();
        test_random_rows();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
